// File: rtl/jt6295_pkg.sv
// Shared types and sizes for the jt6295 sample ROM arbiter.
// State encoding, requester count and ROM map widths.
package jt6295_pkg;

  localparam int NCH     = 4;
  localparam int NREQ    = NCH + 1;
  localparam int ROM_AW  = 18;
  localparam int CTRL_AW = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/jt6295_rr_pick.sv
// Combinational 4-way channel picker.
// Search starts at ptr_i+1 and wraps 3->0.
module jt6295_rr_pick
  import jt6295_pkg::*;
(
  input  logic [NCH-1:0] req_i,
  input  logic [1:0]     ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [1:0]     idx_o,
  output logic           any_o
);

  logic       found;
  logic [1:0] c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 1; i <= NCH; i++) begin
      c = ptr_i + 2'(i);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        idx_o    = c;
        gnt_o[c] = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/jt6295_rom_arb.sv
// Single-port sample ROM arbiter: ctrl first, then channels.
// Define JT6295_ROM_ARB_RR_EN for round-robin channel selection.
module jt6295_rom_arb
  import jt6295_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctrl_req,
  input  logic [CTRL_AW-1:0]  ctrl_addr,
  output logic                ctrl_ack,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH*ROM_AW-1:0] ch_addr,
  output logic [NCH-1:0]      ch_ack,
  output logic [7:0]          dout,
  output logic                busy,
  output logic [ROM_AW-1:0]   rom_addr,
  output logic                rom_cs,
  input  logic [7:0]          rom_data,
  input  logic                rom_ok
);

  state_t            state_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              rom_cs_q;
  logic [7:0]        dout_q;
  logic              ctrl_ack_q;
  logic [NCH-1:0]    ch_ack_q;
  logic              gnt_ctrl_q;
  logic [NCH-1:0]    gnt_q;

  logic [NCH-1:0]    pick_gnt;
  logic [1:0]        pick_idx;
  logic              pick_any;
  logic [1:0]        ptr;
  logic [ROM_AW-1:0] ch_sel;

  jt6295_rr_pick u_pick (
    .req_i (ch_req),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef JT6295_ROM_ARB_RR_EN
  logic [1:0] ptr_q;

  // Pointer moves on channel grants only; ctrl wins leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr_q <= 2'd3;
    else if (state_q == ST_IDLE && !ctrl_req && pick_any)
      ptr_q <= pick_idx;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 2'd3;
`endif

  always_comb begin
    ch_sel = '0;
    unique case (pick_idx)
      2'd0: ch_sel = ch_addr[0*ROM_AW +: ROM_AW];
      2'd1: ch_sel = ch_addr[1*ROM_AW +: ROM_AW];
      2'd2: ch_sel = ch_addr[2*ROM_AW +: ROM_AW];
      2'd3: ch_sel = ch_addr[3*ROM_AW +: ROM_AW];
      default: ch_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      dout_q     <= '0;
      ctrl_ack_q <= 1'b0;
      ch_ack_q   <= '0;
      gnt_ctrl_q <= 1'b0;
      gnt_q      <= '0;
    end else begin
      ctrl_ack_q <= 1'b0;
      ch_ack_q   <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_req) begin
            gnt_ctrl_q <= 1'b1;
            gnt_q      <= '0;
            rom_addr_q <= {8'd0, ctrl_addr};
            rom_cs_q   <= 1'b1;
            state_q    <= ST_GAP;
          end else if (pick_any) begin
            gnt_ctrl_q <= 1'b0;
            gnt_q      <= pick_gnt;
            rom_addr_q <= ch_sel;
            rom_cs_q   <= 1'b1;
            state_q    <= ST_GAP;
          end
        end
        // rom_ok may still describe the previous address here
        ST_GAP: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (rom_ok) begin
            dout_q     <= rom_data;
            ctrl_ack_q <= gnt_ctrl_q;
            ch_ack_q   <= gnt_q;
            rom_cs_q   <= 1'b0;
            state_q    <= ST_ACK;
          end
        end
        ST_ACK: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;
  assign dout     = dout_q;
  assign ctrl_ack = ctrl_ack_q;
  assign ch_ack   = ch_ack_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Directed bench for jt6295_rom_arb: vector table plus
// hand sequences for wait states, drop, reset and fairness.
module tb_jt6295_rom_arb;

  logic        clk;
  logic        rst_n;
  logic        ctrl_req;
  logic [9:0]  ctrl_addr;
  logic        ctrl_ack;
  logic [3:0]  ch_req;
  logic [71:0] ch_addr;
  logic [3:0]  ch_ack;
  logic [7:0]  dout;
  logic        busy;
  logic [17:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data;
  logic        rom_ok;

  int errors = 0;
  int checks = 0;

  jt6295_rom_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl_req  (ctrl_req),
    .ctrl_addr (ctrl_addr),
    .ctrl_ack  (ctrl_ack),
    .ch_req    (ch_req),
    .ch_addr   (ch_addr),
    .ch_ack    (ch_ack),
    .dout      (dout),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] romf(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]};
  endfunction

  assign rom_data = romf(rom_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        creq;
    logic [9:0]  caddr;
    logic [3:0]  chreq;
    logic [71:0] chaddr;
    logic [17:0] eaddr;
    logic        eca;
    logic [3:0]  ech;
  } vec_t;

  vec_t tv[7];

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_vec(input int n, input vec_t v);
    ctrl_req  = v.creq;
    ctrl_addr = v.caddr;
    ch_req    = v.chreq;
    ch_addr   = v.chaddr;
    @(negedge clk);
    chk($sformatf("v%0d rom_addr", n), 32'(rom_addr), 32'(v.eaddr));
    chk($sformatf("v%0d rom_cs", n), 32'(rom_cs), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d early ack", n), 32'({ctrl_ack, ch_ack}), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d ctrl_ack", n), 32'(ctrl_ack), 32'(v.eca));
    chk($sformatf("v%0d ch_ack", n), 32'(ch_ack), 32'(v.ech));
    chk($sformatf("v%0d dout", n), 32'(dout), 32'(romf(v.eaddr)));
    ctrl_req = 1'b0;
    ch_req   = '0;
    @(negedge clk);
    chk($sformatf("v%0d busy", n), 32'(busy), 32'd0);
    chk($sformatf("v%0d ack clr", n), 32'({ctrl_ack, ch_ack}), 32'd0);
  endtask

  initial begin
    int nack;
    int last;
    int who;
    int order[5];
    logic [7:0] edout[5];
    logic [3:0] pend;
    int forder[4];
    int extra;
    int bseen;

    tv[0] = '{1'b1, 10'h3F8, 4'b0000, 72'd0, 18'h003F8, 1'b1, 4'b0000};
    tv[1] = '{1'b0, 10'h000, 4'b0001, {54'd0, 18'h00001},
              18'h00001, 1'b0, 4'b0001};
    tv[2] = '{1'b0, 10'h000, 4'b1000, {18'h3FFFF, 54'd0},
              18'h3FFFF, 1'b0, 4'b1000};
    tv[3] = '{1'b1, 10'h3FF, 4'b0010, {36'd0, 18'h12345, 18'd0},
              18'h003FF, 1'b1, 4'b0000};
    tv[4] = '{1'b0, 10'h000, 4'b0100, {18'd0, 18'h2ABCD, 36'd0},
              18'h2ABCD, 1'b0, 4'b0100};
    tv[5] = '{1'b0, 10'h000, 4'b0110, {18'd0, 18'h2ABCD, 18'h15A3C, 18'd0},
              18'h15A3C, 1'b0, 4'b0010};
`ifdef JT6295_ROM_ARB_RR_EN
    tv[6] = '{1'b0, 10'h000, 4'b1111,
              {18'h30D44, 18'h20C33, 18'h10B22, 18'h00A11},
              18'h20C33, 1'b0, 4'b0100};
`else
    tv[6] = '{1'b0, 10'h000, 4'b1111,
              {18'h30D44, 18'h20C33, 18'h10B22, 18'h00A11},
              18'h00A11, 1'b0, 4'b0001};
`endif

    rst_n     = 1'b0;
    ctrl_req  = 1'b0;
    ctrl_addr = '0;
    ch_req    = '0;
    ch_addr   = '0;
    rom_ok    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    chk("rst rom_cs", 32'(rom_cs), 32'd0);
    chk("rst acks", 32'({ctrl_ack, ch_ack}), 32'd0);
    chk("rst dout", 32'(dout), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, tv[i]);

    // ch2 with five wait cycles in WAIT
    rom_ok  = 1'b0;
    ch_addr = {18'd0, 18'h2ABCD, 36'd0};
    ch_req  = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("ws addr c%0d", k), 32'(rom_addr), 32'h2ABCD);
      chk($sformatf("ws cs c%0d", k), 32'(rom_cs), 32'd1);
      chk($sformatf("ws noack c%0d", k), 32'(ch_ack), 32'd0);
      if (k == 7) rom_ok = 1'b1;
    end
    @(negedge clk);
    chk("ws ch_ack", 32'(ch_ack), 32'b0100);
    chk("ws dout", 32'(dout), 32'(romf(18'h2ABCD)));
    ch_req = '0;
    @(negedge clk);

    // ch1 drops req during GAP
    ch_addr = {36'd0, 18'h0F0F0, 18'd0};
    ch_req  = 4'b0010;
    @(negedge clk);
    ch_req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("drop ch_ack", 32'(ch_ack), 32'b0010);
    chk("drop dout", 32'(dout), 32'(romf(18'h0F0F0)));
    extra = 0;
    bseen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if ({ctrl_ack, ch_ack} != 0) extra++;
      if (busy) bseen++;
    end
    chk("drop regrant ack", 32'(extra), 32'd0);
    chk("drop regrant busy", 32'(bseen), 32'd0);

    // reset during WAIT abandons the access
    rom_ok  = 1'b0;
    ch_addr = {18'd0, 18'h11111, 36'd0};
    ch_req  = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("rmid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmid rom_cs", 32'(rom_cs), 32'd0);
    chk("rmid acks", 32'({ctrl_ack, ch_ack}), 32'd0);
    chk("rmid busy0", 32'(busy), 32'd0);
    chk("rmid rom_addr", 32'(rom_addr), 32'd0);
    chk("rmid dout", 32'(dout), 32'd0);
    ch_req = '0;
    rom_ok = 1'b1;
    rst_n  = 1'b1;

    // ctrl plus all channels, each dropping on its ack
    order = '{4, 0, 1, 2, 3};
    edout[0] = romf(18'h00A11);
    edout[1] = romf(18'h10B22);
    edout[2] = romf(18'h20C33);
    edout[3] = romf(18'h30D44);
    edout[4] = romf(18'h00155);
    ctrl_addr = 10'h155;
    ctrl_req  = 1'b1;
    ch_addr   = {18'h30D44, 18'h20C33, 18'h10B22, 18'h00A11};
    ch_req    = 4'b1111;
    nack = 0;
    last = 0;
    for (int cyc = 1; cyc <= 40 && nack < 5; cyc++) begin
      @(negedge clk);
      if (ctrl_ack || ch_ack != 0) begin
        chk("pre onehot", 32'($countones({ctrl_ack, ch_ack})), 32'd1);
        who = 0;
        if (ctrl_ack) who = 4;
        else for (int j = 0; j < 4; j++) if (ch_ack[j]) who = j;
        chk($sformatf("pre order %0d", nack), 32'(who), 32'(order[nack]));
        chk($sformatf("pre dout %0d", nack), 32'(dout), 32'(edout[who]));
        if (nack == 0) chk("pre first lat", 32'(cyc), 32'd3);
        else chk($sformatf("pre gap %0d", nack), 32'(cyc - last), 32'd4);
        last = cyc;
        nack++;
        if (who == 4) ctrl_req = 1'b0;
        else ch_req[who] = 1'b0;
      end
    end
    chk("pre ack count", 32'(nack), 32'd5);
    ctrl_req = 1'b0;
    ch_req   = '0;
    @(negedge clk);

    // ch0 and ch3 re-request one cycle after each ack
`ifdef JT6295_ROM_ARB_RR_EN
    forder = '{0, 3, 0, 3};
`else
    forder = '{0, 0, 0, 0};
`endif
    ch_addr = {18'h3FF00, 36'd0, 18'h00055};
    ch_req  = 4'b1001;
    pend = '0;
    nack = 0;
    for (int cyc = 1; cyc <= 60 && nack < 4; cyc++) begin
      @(negedge clk);
      ch_req = ch_req | pend;
      pend   = '0;
      if (ch_ack != 0) begin
        who = 0;
        for (int j = 0; j < 4; j++) if (ch_ack[j]) who = j;
        chk($sformatf("fair grant %0d", nack), 32'(who), 32'(forder[nack]));
        nack++;
        pend   = ch_ack;
        ch_req = ch_req & ~ch_ack;
      end
    end
    chk("fair ack count", 32'(nack), 32'd4);
    ch_req = '0;
    repeat (6) @(negedge clk);
    chk("end busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt6295_rom_arb.md
# jt6295_rom_arb

Shares the single external sample ROM port between five requesters: the phrase-table fetcher and the four ADPCM channel engines. Each requester raises a request with an address and gets back one byte plus a one-cycle acknowledge. The block sits between the control/channel logic and the top-level `rom_addr`/`rom_cs`/`rom_data`/`rom_ok` pins. It serialises the accesses, holds the address stable until data is valid, and arbitrates among the channels.

## Interface
- No parameters; widths are fixed by the 256 KB sample ROM map.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous reset, active-low.
- `ctrl_req` in 1: phrase-table fetch request.
- `ctrl_addr` in 10: phrase-table byte address; maps to ROM `{8'd0, ctrl_addr}`.
- `ctrl_ack` out 1: one-cycle pulse; `dout` is valid for the control request.
- `ch_req` in 4: per-channel fetch request.
- `ch_addr` in 4×18 (72, ch0 in [17:0]): per-channel byte address.
- `ch_ack` out 4: one-hot, one-cycle pulse per completed channel fetch.
- `dout` out 8: fetched byte; valid in the ack cycle and held until the next ack.
- `busy` out 1: high whenever the state is not IDLE.
- `rom_addr` out 18: ROM address, registered.
- `rom_cs` out 1: ROM chip select, registered.
- `rom_data` in 8: ROM data.
- `rom_ok` in 1: ROM data valid for the current address.

## Operation
- **States:** IDLE, GAP, WAIT, ACK.
- **IDLE**
  - With no request pending, the block stays in IDLE.
  - Otherwise it picks a grant, registers `rom_addr` for the granted requester, sets `rom_cs`=1 and moves to GAP.
- **GAP:** one dead cycle. `rom_ok` is ignored here because it may still refer to the previous address. Always moves to WAIT.
- **WAIT**
  - Holds `rom_addr` and `rom_cs`.
  - On `rom_ok`=1: registers `rom_data` into `dout`, pulses the granted ack, sets `rom_cs`=0 and moves to ACK.
- **ACK:** no arbitration takes place in this cycle, so a requester that drops `req` on seeing ack is never granted twice. Always moves to IDLE.
- **Priority**
  - `ctrl_req` always has top priority over all channels.
  - Channel selection is set by the configuration macro.
- **Request rule:** a requester must hold `req` and `addr` until its ack.
  - If `req` drops while granted, the access still completes and the ack still pulses.
  - `addr` is sampled only in IDLE; changes after that are ignored.
- **Reset values:** `rom_addr`=0, `rom_cs`=0, `ctrl_ack`=0, `ch_ack`=0, `dout`=0, `busy`=0, state IDLE, round-robin pointer=3 (so ch0 is searched first).
- **Reset mid-access:** the access is abandoned with no ack. `rom_cs` drops at the reset edge.
- **No timeout:** WAIT waits indefinitely for `rom_ok`.

## Timing
- `req` sampled in IDLE at cycle N:
  - `rom_addr`/`rom_cs` valid from N+1 (GAP).
  - `rom_ok` first sampled at N+2.
  - With `rom_ok` already high: ack and `dout` valid at N+3.
  - Next arbitration at N+4.
- Each additional cycle of `rom_ok`=0 in WAIT adds one cycle.
- Maximum throughput is one byte per 4 cycles.
- `rom_addr` never changes while `rom_cs`=1.
- Exactly one ack bit (`ctrl_ack` or one `ch_ack` bit) is high per completed access; at most one per cycle.

## Configuration
- **`JT6295_ROM_ARB_RR_EN` defined:** round-robin among channels.
  - The search starts at (last granted channel + 1) mod 4, wrapping 3→0.
  - The pointer updates only on a channel grant, not on a ctrl grant.
- **Not defined:** fixed channel priority ch0 > ch1 > ch2 > ch3. No pointer register exists.
- `ctrl_req` has top priority in both builds.

## Structure
- **Shared package `jt6295_pkg`:**
  - State encoding constants (IDLE=0, GAP=1, WAIT=2, ACK=3).
  - Requester count (4 channels + ctrl).
  - ROM address width (18).
  - Phrase-table width (10).
- **Sub-module `jt6295_rr_pick`:** combinational 4-way picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-request flag.
  - In the fixed-priority build the pointer is tied to 3.

## Test plan
- **Single ctrl fetch:** `ctrl_req`=1, `ctrl_addr`=0x3F8, `rom_ok` always 1.
  - `rom_addr`=0x003F8 at N+1.
  - `ctrl_ack` pulse with `dout`=`rom_data` at N+3.
  - `busy` low at N+4.
- **ROM wait states:** ch2 requests 0x2ABCD; `rom_ok` held low 5 cycles in WAIT.
  - `rom_addr` stable at 0x2ABCD throughout.
  - `ch_ack`=4'b0100 at N+8.
- **Ctrl preemption:** ctrl and all four channels request together.
  - First grant goes to ctrl.
  - Then ch0, ch1, ch2, ch3 (round-robin build).
  - Acks spaced 4 cycles apart with `rom_ok`=1.
- **Round-robin fairness:** ch0 and ch3 request continuously, dropping `req` for one cycle after each ack.
  - RR build: grants alternate ch0, ch3, ch0, ch3.
  - Fixed-priority build: ch3 is starved while ch0 re-requests.
- **Early request drop:** ch1 drops `req` during GAP.
  - The access completes.
  - `ch_ack[1]` still pulses.
  - No second grant to ch1.
- **Reset mid-access:** `rst_n`=0 during WAIT.
  - `rom_cs`=0 and all acks 0 at the next edge.
  - After release, a ch0 request is granted first.
